// File: rtl/apb_slave_module.sv
// APB slave bridge in front of the matrix-multiplier register file.
// Optional build macro APB_STRB_EN: per-element write strobes derived from pstrb_i.
module apb_slave_module #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BUS_WIDTH   = 64,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned SP_NTARGETS = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            psel_i,
  input  logic                            penable_i,
  input  logic                            pwrite_i,
  input  logic [ADDR_WIDTH-1:0]           paddr_i,
  input  logic [BUS_WIDTH-1:0]            pwdata_i,
  input  logic [BUS_WIDTH/8-1:0]          pstrb_i,
  output logic [BUS_WIDTH-1:0]            prdata_o,
  output logic                            pready_o,
  output logic                            pslverr_o,
  output logic [ADDR_WIDTH-1:0]           address_o,
  output logic [BUS_WIDTH-1:0]            data_o,
  output logic                            write_enable_o,
  output logic [BUS_WIDTH/DATA_WIDTH-1:0] strobe_o,
  input  logic [BUS_WIDTH-1:0]            data_i,
  input  logic                            busy_i
);

  localparam int unsigned MAX_DIM        = BUS_WIDTH / DATA_WIDTH;
  localparam int unsigned IDX_W          = ADDR_WIDTH - 5;
  localparam int unsigned BYTES_PER_ELEM = DATA_WIDTH / 8;

  localparam logic [4:0] REG_CONTROL   = 5'b00000;
  localparam logic [4:0] REG_OPERAND_A = 5'b00100;
  localparam logic [4:0] REG_FLAGS     = 5'b01000;
  localparam logic [4:0] REG_OPERAND_B = 5'b01100;
  localparam logic [4:0] REG_SP        = 5'b10000;

  localparam logic [IDX_W-1:0] IDX_DIM_LIMIT = IDX_W'(MAX_DIM);
  localparam logic [IDX_W-1:0] IDX_SP_LIMIT  = IDX_W'(SP_NTARGETS * MAX_DIM);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETUP   = 2'd1;
  localparam logic [1:0] ST_ACCESS  = 2'd2;
  localparam logic [1:0] ST_RD_DONE = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [1:0]            state_cur;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BUS_WIDTH-1:0]  wdata_q, wdata_d;
  logic [BUS_WIDTH-1:0]  prdata_q, prdata_d;
  logic                  wr_q, wr_d;
  logic                  dec_err_q, dec_err_d;
  logic                  busy_chk_q, busy_chk_d;

  logic [4:0]            region;
  logic [IDX_W-1:0]      idx;
  logic                  dec_bad;
  logic                  dec_ro;
  logic                  acc_err;
  logic                  bus_acc;
  logic                  strobe_any;

  // Region and row decode of the address currently on the bus.
  always_comb begin
    region  = paddr_i[4:0];
    idx     = paddr_i[ADDR_WIDTH-1:5];
    dec_bad = 1'b1;
    dec_ro  = 1'b0;
    case (region)
      REG_CONTROL:   dec_bad = (idx != '0);
      REG_OPERAND_A: dec_bad = (idx >= IDX_DIM_LIMIT);
      REG_OPERAND_B: dec_bad = (idx >= IDX_DIM_LIMIT);
      REG_FLAGS: begin
        dec_bad = (idx != '0);
        dec_ro  = 1'b1;
      end
      REG_SP: begin
        dec_bad = (idx >= IDX_SP_LIMIT);
        dec_ro  = 1'b1;
      end
      default: dec_bad = 1'b1;
    endcase
  end

  // SETUP is recognised in the same cycle the bus presents it, so the
  // registered ACCESS state lines up with the first PENABLE cycle.
  always_comb begin
    state_cur = state_q;
    if (state_q == ST_IDLE && psel_i && !penable_i) begin
      state_cur = ST_SETUP;
    end
  end

  assign bus_acc = psel_i && penable_i;
  assign acc_err = dec_err_q || (busy_chk_q && busy_i);

`ifdef APB_STRB_EN
  logic [MAX_DIM-1:0] strb_q, strb_d;
  logic [MAX_DIM-1:0] strb_elem;

  always_comb begin
    strb_elem = '0;
    for (int unsigned e = 0; e < MAX_DIM; e++) begin
      strb_elem[e] = |pstrb_i[e*BYTES_PER_ELEM +: BYTES_PER_ELEM];
    end
  end

  always_comb begin
    strb_d = strb_q;
    if (state_cur == ST_SETUP) begin
      strb_d = strb_elem;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      strb_q <= '0;
    end else begin
      strb_q <= strb_d;
    end
  end

  assign strobe_any = |strb_q;
  assign strobe_o   = strb_q;
`else
  logic unused_pstrb;

  assign unused_pstrb = ^pstrb_i;
  assign strobe_any   = 1'b1;
  assign strobe_o     = {MAX_DIM{write_enable_o}};
`endif

  always_comb begin
    state_d        = ST_IDLE;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    wr_d           = wr_q;
    dec_err_d      = dec_err_q;
    busy_chk_d     = busy_chk_q;
    prdata_d       = prdata_q;
    pready_o       = 1'b0;
    pslverr_o      = 1'b0;
    write_enable_o = 1'b0;
    case (state_cur)
      ST_SETUP: begin
        state_d    = ST_ACCESS;
        addr_d     = paddr_i;
        wdata_d    = pwdata_i;
        wr_d       = pwrite_i;
        dec_err_d  = dec_bad || (pwrite_i && dec_ro);
        busy_chk_d = pwrite_i && !dec_bad && !dec_ro;
      end
      ST_ACCESS: begin
        if (!bus_acc) begin
          state_d = ST_IDLE;
        end else if (wr_q) begin
          state_d        = ST_IDLE;
          pready_o       = 1'b1;
          pslverr_o      = acc_err;
          write_enable_o = !acc_err && strobe_any;
        end else begin
          state_d  = ST_RD_DONE;
          prdata_d = acc_err ? '0 : data_i;
        end
      end
      ST_RD_DONE: begin
        state_d = ST_IDLE;
        if (psel_i) begin
          pready_o  = 1'b1;
          pslverr_o = dec_err_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      prdata_q   <= '0;
      wr_q       <= 1'b0;
      dec_err_q  <= 1'b0;
      busy_chk_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      prdata_q   <= prdata_d;
      wr_q       <= wr_d;
      dec_err_q  <= dec_err_d;
      busy_chk_q <= busy_chk_d;
    end
  end

  assign address_o = addr_q;
  assign data_o    = wdata_q;
  assign prdata_o  = prdata_q;

endmodule

// File: tb/tb_apb_slave_module.sv
// Self-checking bench for apb_slave_module: scoreboarded APB transfers,
// decode/error cases, busy blocking, reset mid-read, back-to-back and abort.
module tb_apb_slave_module;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel, penable, pwrite;
  logic [31:0] paddr;
  logic [63:0] pwdata;
  logic [7:0]  pstrb;
  logic [63:0] prdata_o;
  logic        pready_o, pslverr_o;
  logic [31:0] address_o;
  logic [63:0] data_o;
  logic        write_enable_o;
  logic [1:0]  strobe_o;
  logic [63:0] rf_rdata;
  logic        busy;

  always #5 clk = ~clk;

  apb_slave_module #(
    .DATA_WIDTH (32),
    .BUS_WIDTH  (64),
    .ADDR_WIDTH (32),
    .SP_NTARGETS(4)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .psel_i        (psel),
    .penable_i     (penable),
    .pwrite_i      (pwrite),
    .paddr_i       (paddr),
    .pwdata_i      (pwdata),
    .pstrb_i       (pstrb),
    .prdata_o      (prdata_o),
    .pready_o      (pready_o),
    .pslverr_o     (pslverr_o),
    .address_o     (address_o),
    .data_o        (data_o),
    .write_enable_o(write_enable_o),
    .strobe_o      (strobe_o),
    .data_i        (rf_rdata),
    .busy_i        (busy)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit          err;
    bit          wr;
    bit          we;
    logic [1:0]  strb;
    logic [63:0] rdata;
    int unsigned waits;
  } exp_t;

  exp_t sb_q[$];

  // Reference decode: MAX_DIM=2, SP rows=8.
  function automatic bit model_err(input bit wr, input logic [31:0] a, input bit bsy);
    logic [26:0] row;
    row = a[31:5];
    case (a[4:0])
      5'h00:        return (row != 0) || (wr && bsy);
      5'h04, 5'h0C: return (row > 1) || (wr && bsy);
      5'h08:        return (row != 0) || wr;
      5'h10:        return (row > 7) || wr;
      default:      return 1'b1;
    endcase
  endfunction

  task automatic apb_xfer(input string tag, input bit wr, input logic [31:0] addr,
                          input logic [63:0] wdata, input logic [7:0] strb,
                          input bit bsy, input logic [63:0] rd);
    exp_t        e;
    exp_t        got_e;
    int unsigned we_cnt;
    bit          done;
    we_cnt  = 0;
    done    = 1'b0;
    e.err   = model_err(wr, addr, bsy);
    e.wr    = wr;
    e.rdata = e.err ? 64'd0 : rd;
`ifdef APB_STRB_EN
    e.we    = wr && !e.err && (strb != 8'h00);
    e.strb  = {|strb[7:4], |strb[3:0]};
`else
    e.we    = wr && !e.err;
    e.strb  = e.we ? 2'b11 : 2'b00;
`endif
    e.waits = wr ? 0 : 1;
    got_e   = e;

    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
    pwdata = wdata; pstrb = strb; busy = bsy; rf_rdata = rd;
    sb_q.push_back(e);
    @(negedge clk);
    check_eq({tag, " setup pready"}, {63'd0, pready_o}, 64'd0);
    @(posedge clk); #1;
    penable = 1'b1;
    for (int unsigned cyc = 0; cyc < 4 && !done; cyc++) begin
      @(negedge clk);
      if (write_enable_o) begin
        we_cnt++;
        check_eq({tag, " address_o"}, {32'd0, address_o}, {32'd0, addr});
        check_eq({tag, " data_o"}, data_o, wdata);
      end
      if (pready_o) begin
        done = 1'b1;
        if (sb_q.size() == 0) begin
          check_eq({tag, " scoreboard empty"}, 64'(sb_q.size()), 64'd1);
        end else begin
          got_e = sb_q.pop_front();
          check_eq({tag, " wait states"}, 64'(cyc), 64'(got_e.waits));
          check_eq({tag, " pslverr"}, {63'd0, pslverr_o}, {63'd0, got_e.err});
          check_eq({tag, " strobe"}, {62'd0, strobe_o}, {62'd0, got_e.strb});
          if (!got_e.wr) check_eq({tag, " prdata"}, prdata_o, got_e.rdata);
        end
      end
    end
    check_eq({tag, " pready seen"}, {63'd0, done}, 64'd1);
    if (!done && sb_q.size() != 0) got_e = sb_q.pop_front();
    check_eq({tag, " write pulses"}, 64'(we_cnt), {63'd0, got_e.we});
  endtask

  task automatic bus_idle(input string tag);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    check_eq({tag, " idle quiet"}, {62'd0, pready_o, write_enable_o}, 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, " pready"}, {63'd0, pready_o}, 64'd0);
    check_eq({tag, " pslverr"}, {63'd0, pslverr_o}, 64'd0);
    check_eq({tag, " prdata"}, prdata_o, 64'd0);
    check_eq({tag, " address"}, {32'd0, address_o}, 64'd0);
    check_eq({tag, " data"}, data_o, 64'd0);
    check_eq({tag, " we"}, {63'd0, write_enable_o}, 64'd0);
    check_eq({tag, " strobe"}, {62'd0, strobe_o}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = 8'hFF; rf_rdata = '0; busy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    apb_xfer("wr ctrl",      1'b1, 32'h00,  64'h105,                 8'hFF, 1'b0, 64'h0);
    bus_idle("i1");
    apb_xfer("rd opa1",      1'b0, 32'h24,  64'h0,                   8'hFF, 1'b0, 64'h1111_2222_3333_4444);
    bus_idle("i2");
    apb_xfer("wr opb busy",  1'b1, 32'h0C,  64'hDEAD,                8'hFF, 1'b1, 64'h0);
    apb_xfer("wr flags",     1'b1, 32'h08,  64'h1,                   8'hFF, 1'b0, 64'h0);
    apb_xfer("rd sp8",       1'b0, 32'h110, 64'h0,                   8'hFF, 1'b0, 64'hAAAA_BBBB_CCCC_DDDD);
    apb_xfer("rd flags bsy", 1'b0, 32'h08,  64'h0,                   8'hFF, 1'b1, 64'h0000_0000_0000_0001);
    apb_xfer("rd sp7",       1'b0, 32'hF0,  64'h0,                   8'hFF, 1'b0, 64'h0123_4567_89AB_CDEF);
    apb_xfer("wr opa2",      1'b1, 32'h44,  64'h5,                   8'hFF, 1'b0, 64'h0);
    apb_xfer("wr region14",  1'b1, 32'h14,  64'h6,                   8'hFF, 1'b0, 64'h0);
    apb_xfer("wr ctrl1",     1'b1, 32'h20,  64'h7,                   8'hFF, 1'b0, 64'h0);
    apb_xfer("wr opb1",      1'b1, 32'h2C,  64'h8888_9999_AAAA_BBBB, 8'hFF, 1'b0, 64'h0);
    apb_xfer("wr strb f0",   1'b1, 32'h24,  64'hCAFE_0000_0000_0000, 8'hF0, 1'b0, 64'h0);
    apb_xfer("wr strb 00",   1'b1, 32'h04,  64'h1234,                8'h00, 1'b0, 64'h0);
    apb_xfer("rd opa1 b",    1'b0, 32'h24,  64'h0,                   8'hFF, 1'b0, 64'h5555_6666_7777_8888);
    bus_idle("i3");

    // Reset asserted during the read wait state.
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h2C; pwdata = 64'h77; rf_rdata = 64'h9999;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    check_eq("rst wait pready", {63'd0, pready_o}, 64'd0);
    #1 rst_n = 1'b0;
    #1 check_all_zero("rst mid read");
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    check_eq("rst held pready", {63'd0, pready_o}, 64'd0);
    rst_n = 1'b1;
    apb_xfer("rd opa0 post", 1'b0, 32'h04, 64'h0, 8'hFF, 1'b0, 64'hFEED_FACE_0BAD_F00D);

    // Back-to-back write then read with no idle cycle.
    apb_xfer("b2b wr",       1'b1, 32'h04, 64'h4444, 8'hFF, 1'b0, 64'h0);
    apb_xfer("b2b rd",       1'b0, 32'h2C, 64'h0,    8'hFF, 1'b0, 64'h2C2C_2C2C_2C2C_2C2C);
    bus_idle("i4");

    // psel dropped while the slave is in ACCESS.
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h04; pwdata = 64'hBAD; busy = 1'b0;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    check_eq("abort quiet", {62'd0, pready_o, write_enable_o}, 64'd0);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b1;
    @(negedge clk);
    check_eq("stray enable 1", {62'd0, pready_o, write_enable_o}, 64'd0);
    @(negedge clk);
    check_eq("stray enable 2", {62'd0, pready_o, write_enable_o}, 64'd0);
    bus_idle("i5");
    apb_xfer("post abort wr", 1'b1, 32'h00, 64'h3, 8'hFF, 1'b0, 64'h0);
    bus_idle("i6");

    check_eq("scoreboard drained", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_slave_module.md
Name: apb_slave_module

Overview:
- APB slave bridge directly upstream of the matrix-multiplier register file.
- Converts APB SETUP/ACCESS transactions into register-file accesses: address, write data, write enable, lane strobe, and captured read data.
- Decodes the region and element index, and rejects illegal accesses with PSLVERR.
- Blocks operand and control writes while the engine is busy.

Parameters:
DATA_WIDTH, 32, matrix element width in bits
BUS_WIDTH, 64, APB data bus width in bits; MAX_DIM = BUS_WIDTH/DATA_WIDTH (localparam)
ADDR_WIDTH, 32, APB address width in bits
SP_NTARGETS, 4, number of scratchpad matrices; SP rows = SP_NTARGETS*MAX_DIM

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
psel_i  in  1  APB select
penable_i  in  1  APB enable
pwrite_i  in  1  APB write(1)/read(0)
paddr_i  in  ADDR_WIDTH  APB address
pwdata_i  in  BUS_WIDTH  APB write data
pstrb_i  in  BUS_WIDTH/8  APB byte strobes
prdata_o  out  BUS_WIDTH  APB read data
pready_o  out  1  APB ready
pslverr_o  out  1  APB error, qualified by pready_o
address_o  out  ADDR_WIDTH  register-file address
data_o  out  BUS_WIDTH  register-file write data
write_enable_o  out  1  register-file write pulse
strobe_o  out  MAX_DIM  per-element write strobe
data_i  in  BUS_WIDTH  register-file read data (combinational from address_o)
busy_i  in  1  engine busy (start bit set)

Behaviour:
- Reset (async, rst_ni=0): state IDLE; prdata_o, pready_o, pslverr_o, address_o, data_o, write_enable_o, strobe_o all 0. Reset takes effect immediately, including mid-transaction. Any in-flight access is dropped with no write.
- Address decode: paddr[4:0] selects region, paddr[ADDR_WIDTH-1:5] is the row index (idx).
  - CONTROL = 5'b00000: idx must be 0; read/write.
  - OPERAND_A = 5'b00100: idx < MAX_DIM; read/write.
  - FLAGS = 5'b01000: idx must be 0; read-only.
  - OPERAND_B = 5'b01100: idx < MAX_DIM; read/write.
  - SP = 5'b10000: idx < SP_NTARGETS*MAX_DIM; read-only.
  - Any other code, or idx out of range, is an error.
- Error conditions: write to FLAGS or SP; write to CONTROL, OPERAND_A or OPERAND_B while busy_i=1 (sampled in the first ACCESS cycle). Reads are always allowed.
- FSM states:
  - IDLE → SETUP when psel_i=1 and penable_i=0. penable_i=1 without a prior SETUP is ignored; stay in IDLE.
  - SETUP: register paddr_i→address_o, pwdata_i→data_o, pwrite, and the decode/error result. Go to ACCESS next cycle.
  - ACCESS, write (first cycle, psel_i=1, penable_i=1): pready_o=1. If no error, write_enable_o=1 for this single cycle, pslverr_o=0. On error, write_enable_o=0, pslverr_o=1. Next state IDLE.
  - ACCESS, read: pready_o=0. Capture data_i into prdata_o (0 on error) at the clock edge. Go to RD_DONE.
  - RD_DONE: pready_o=1, pslverr_o=error, prdata_o held. Next state IDLE.
- Latency: writes complete with zero wait states; reads insert exactly one wait state.
- Outside a completing cycle: pready_o=0 and pslverr_o=0. prdata_o holds its last value until the next read captures.
- Abort: if psel_i drops in ACCESS or RD_DONE, return to IDLE with no write and no pready.
- Back-to-back transfers: psel_i=1 with penable_i=0 in the cycle after completion enters SETUP directly; no idle cycle is required.
- address_o and data_o hold their SETUP values until the next SETUP.

Optional Feature:
- Macro: APB_STRB_EN.
- Defined: strobe_o[i] = OR of pstrb_i bytes covering element i, registered in SETUP. A write whose strobe_o is all zero still completes with pready_o=1, but write_enable_o stays 0.
- Undefined: pstrb_i is ignored; strobe_o is all ones whenever write_enable_o=1, otherwise 0.

Test Plan (BUS_WIDTH=64, MAX_DIM=2, SP_NTARGETS=4):
- Write paddr=0x00, pwdata=0x0000_0000_0000_0105, busy_i=0 → in ACCESS: write_enable_o=1 for one cycle, address_o=0x00, data_o=0x105, pready_o=1, pslverr_o=0.
- Read paddr=0x24 (OPERAND_A row 1), data_i=0x1111_2222_3333_4444 → first ACCESS pready_o=0; next cycle pready_o=1, prdata_o=0x1111_2222_3333_4444, pslverr_o=0.
- Write paddr=0x0C with busy_i=1 → pready_o=1, pslverr_o=1, write_enable_o never asserts. Write paddr=0x08 → pslverr_o=1. Read paddr=0x110 (SP idx 8) → pslverr_o=1, prdata_o=0.
- rst_ni pulled low during the read wait state → outputs 0 immediately, no pready. After release, a read of 0x04 completes normally.
- Back-to-back write 0x04 then read 0x2C with no idle cycle → one write pulse, then read data returned after one wait state. Dropping psel_i mid-ACCESS → no write_enable_o, FSM back to IDLE.
- APB_STRB_EN defined: pstrb_i=0xF0 → strobe_o=2'b10; pstrb_i=0x00 → pready_o=1, write_enable_o=0. Undefined: strobe_o=2'b11 on every write.
